// File: rtl/ram_access_ctrl_if.sv
// Client-side request and response channels of ram_access_ctrl.
// The master modport is the client; the slave modport is the controller.
interface ram_access_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [LEN_WIDTH-1:0]  req_len;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_last;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_last
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_last
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// Burst initiator for a single-port synchronous RAM: fill bursts, and read bursts
// that absorb the 1-cycle RAM read latency and honour response back-pressure.
module ram_access_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_access_ctrl_if.slave      bus,
  output logic                  busy,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);
  localparam int unsigned CNT_WIDTH = LEN_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_CAPT,
    RD_RESP
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  // Beats still to transfer, including the current one.
  logic [CNT_WIDTH-1:0]  beats_q, beats_d;
  logic                  last_beat;

  assign last_beat = (beats_q == CNT_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      beats_q <= beats_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    beats_d       = beats_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_last  = 1'b0;
    bus.rsp_data  = rdata_q;
    busy          = 1'b1;
    ram_we        = 1'b0;
    ram_addr      = cur_q;
    ram_din       = wdata_q;

    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        busy          = 1'b0;
        if (bus.req_valid) begin
          cur_d   = bus.req_addr;
          wdata_d = bus.req_wdata;
          beats_d = CNT_WIDTH'(bus.req_len) + CNT_WIDTH'(1);
          state_d = bus.req_we ? WR : RD_ISSUE;
        end
      end
      WR: begin
        // Gated by rst_n so a reset edge landing mid-fill never commits that beat.
        ram_we = rst_n;
        if (last_beat) begin
          state_d = IDLE;
        end else begin
          cur_d   = cur_q + 1'b1;
          beats_d = beats_q - 1'b1;
        end
      end
      RD_ISSUE: begin
        state_d = RD_CAPT;
      end
      RD_CAPT: begin
        rdata_d = ram_dout;
        state_d = RD_RESP;
      end
      RD_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_last  = last_beat;
        if (bus.rsp_ready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            cur_d   = cur_q + 1'b1;
            beats_d = beats_q - 1'b1;
            state_d = RD_ISSUE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifndef SYNTHESIS
  a_rsp_hold: assert property (@(posedge clk)
    (rst_n && bus.rsp_valid && !bus.rsp_ready) |=>
      (bus.rsp_valid && $stable(bus.rsp_data) && $stable(bus.rsp_last)));

  a_beats_live: assert property (@(posedge clk)
    (state_q != IDLE) |-> (beats_q != '0));
`endif
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Randomised self-checking bench for ram_access_ctrl, checked against a
// burst-level memory model and a log of RAM write cycles.
module tb_ram_access_ctrl;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned LW    = 4;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned TMO   = 40;
  localparam int unsigned NONE  = 999;

  typedef struct {
    int unsigned   cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          busy;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  int checks = 0;
  int errors = 0;

  ram_access_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  ram_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM, preloaded with a fixed pattern on the first edge.
  logic [DW-1:0] ram_mem [DEPTH];
  logic          ram_init_done = 1'b0;
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < int'(DEPTH); i++) ram_mem[i] <= DW'(i * 37 + 11);
      ram_init_done <= 1'b1;
    end else if (ram_we) begin
      ram_mem[ram_addr] <= ram_din;
    end
    ram_dout <= ram_mem[ram_addr];
  end

  int unsigned cyc = 0;
  wr_t         wr_log[$];
  always @(posedge clk) begin
    if (ram_we) wr_log.push_back(wr_t'{cyc, ram_addr, ram_din});
    cyc <= cyc + 1;
  end

  logic [DW-1:0] model_mem [DEPTH];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_req(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] len,
                          input logic [DW-1:0] d, output int unsigned waited,
                          output int unsigned acc, output bit ok);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_len   = len;
    bus.req_wdata = d;
    waited = 0;
    while (!bus.req_ready && waited < TMO) begin
      @(negedge clk);
      waited++;
    end
    ok = bus.req_ready;
    if (ok) @(negedge clk);
    acc = cyc;
    bus.req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] len, input logic [DW-1:0] d);
    int unsigned waited, acc, n, base, nb;
    bit ok;
    base = wr_log.size();
    nb   = int'(len) + 1;
    send_req(1'b1, a, len, d, waited, acc, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wr_accept: req_ready never high, waited %0d", waited);
      return;
    end
    n = 0;
    while (busy && n < TMO) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_done: busy=%b after %0d cycles, want 0", busy, n);
    end
    checks++;
    if (wr_log.size() - base !== nb) begin
      errors++;
      $display("FAIL wr_count: got %0d RAM writes, want %0d", wr_log.size() - base, nb);
    end
    for (int unsigned i = 0; i < nb && base + i < wr_log.size(); i++) begin
      checks++;
      if (wr_log[base+i].addr !== AW'(a + i) || wr_log[base+i].data !== d ||
          wr_log[base+i].cyc !== acc + i) begin
        errors++;
        $display("FAIL wr_beat %0d: addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d",
                 i, wr_log[base+i].addr, wr_log[base+i].data, wr_log[base+i].cyc,
                 AW'(a + i), d, acc + i);
      end
    end
    for (int unsigned i = 0; i < nb; i++) model_mem[AW'(a + i)] = d;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] len,
                         input int unsigned stall_beat, input int unsigned stall_cycles,
                         input bit rnd);
    int unsigned waited, ref_cyc, n, st;
    logic [DW-1:0] exp_d;
    logic exp_last;
    bit ok;
    send_req(1'b0, a, len, '0, waited, ref_cyc, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rd_accept: req_ready never high, waited %0d", waited);
      return;
    end
    for (int unsigned b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!bus.rsp_valid && n < TMO) begin
        @(negedge clk);
        n++;
      end
      exp_d    = model_mem[AW'(a + b)];
      exp_last = (b == int'(len));
      checks++;
      if (bus.rsp_valid !== 1'b1) begin
        errors++;
        $display("FAIL rd_timeout beat %0d: rsp_valid=%b, want 1", b, bus.rsp_valid);
        return;
      end
      checks++;
      if (cyc - ref_cyc !== 2) begin
        errors++;
        $display("FAIL rd_latency beat %0d: valid %0d edges after accept/handshake, want 2",
                 b, cyc - ref_cyc);
      end
      checks++;
      if (bus.rsp_data !== exp_d || bus.rsp_last !== exp_last) begin
        errors++;
        $display("FAIL rd_data beat %0d addr %0d: data=%h last=%b, want data=%h last=%b",
                 b, AW'(a + b), bus.rsp_data, bus.rsp_last, exp_d, exp_last);
      end
      st = (b == stall_beat) ? stall_cycles : (rnd ? $urandom_range(0, 2) : 0);
      for (int unsigned s = 0; s < st; s++) begin
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_d || bus.rsp_last !== exp_last ||
            ram_we !== 1'b0) begin
          errors++;
          $display("FAIL rd_hold beat %0d stall %0d: valid=%b data=%h last=%b we=%b, want 1 %h %b 0",
                   b, s, bus.rsp_valid, bus.rsp_data, bus.rsp_last, ram_we, exp_d, exp_last);
        end
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      ref_cyc = cyc;
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL rd_dup beat %0d: rsp_valid=%b after handshake, want 0", b, bus.rsp_valid);
      end
    end
    checks++;
    if (busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_idle: busy=%b req_ready=%b after last beat, want 0 1", busy, bus.req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_last !== 1'b0 ||
        bus.rsp_data !== '0 || busy !== 1'b0 || ram_we !== 1'b0 || ram_addr !== '0 ||
        ram_din !== '0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b last=%b data=%h busy=%b we=%b addr=%h din=%h, want 1 0 0 00 0 0 0 00",
               bus.req_ready, bus.rsp_valid, bus.rsp_last, bus.rsp_data, busy, ram_we,
               ram_addr, ram_din);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_beat();
    do_write(4'd3, 4'd0, 8'hA5);
    do_read(4'd3, 4'd0, NONE, 0, 1'b0);
  endtask

  task automatic test_wrap();
    do_write(4'd14, 4'd3, 8'h5C);
    do_read(4'd14, 4'd3, NONE, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_read(4'd13, 4'd2, 0, 5, 1'b0);
  endtask

  task automatic test_busy_hold();
    int unsigned waited, acc1, acc2, base, n;
    bit ok1, ok2;
    base = wr_log.size();
    send_req(1'b1, 4'd5, 4'd5, 8'h71, waited, acc1, ok1);
    send_req(1'b1, 4'd8, 4'd1, 8'h2E, waited, acc2, ok2);
    checks++;
    if (!ok1 || !ok2 || waited !== 6 || acc2 !== acc1 + 7) begin
      errors++;
      $display("FAIL busy_hold_accept: ok=%b%b waited=%0d gap=%0d, want ok=11 waited=6 gap=7",
               ok1, ok2, waited, acc2 - acc1);
    end
    n = 0;
    while (busy && n < TMO) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (wr_log.size() - base !== 8) begin
      errors++;
      $display("FAIL busy_hold_count: got %0d RAM writes, want 8", wr_log.size() - base);
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        int unsigned   ec;
        ea = (i < 6) ? AW'(5 + i) : AW'(8 + i - 6);
        ed = (i < 6) ? 8'h71 : 8'h2E;
        ec = (i < 6) ? acc1 + i : acc2 + i - 6;
        checks++;
        if (wr_log[base+i].addr !== ea || wr_log[base+i].data !== ed || wr_log[base+i].cyc !== ec) begin
          errors++;
          $display("FAIL busy_hold_beat %0d: addr=%0d data=%h cyc=%0d, want %0d %h %0d",
                   i, wr_log[base+i].addr, wr_log[base+i].data, wr_log[base+i].cyc, ea, ed, ec);
        end
      end
    end
    for (int unsigned i = 0; i < 6; i++) model_mem[AW'(5 + i)] = 8'h71;
    for (int unsigned i = 0; i < 2; i++) model_mem[AW'(8 + i)] = 8'h2E;
    do_read(4'd5, 4'd5, NONE, 0, 1'b0);
  endtask

  task automatic test_reset_midburst();
    int unsigned waited, acc, base;
    bit ok;
    base = wr_log.size();
    send_req(1'b1, 4'd2, 4'd7, 8'h3C, waited, acc, ok);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_last !== 1'b0 ||
        bus.rsp_data !== '0 || busy !== 1'b0 || ram_we !== 1'b0 || ram_addr !== '0 ||
        ram_din !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: rdy=%b vld=%b last=%b data=%h busy=%b we=%b addr=%h din=%h",
               bus.req_ready, bus.rsp_valid, bus.rsp_last, bus.rsp_data, busy, ram_we,
               ram_addr, ram_din);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || wr_log.size() - base !== 2) begin
      errors++;
      $display("FAIL mid_reset_writes: ok=%b got %0d RAM writes, want 2", ok, wr_log.size() - base);
    end
    model_mem[2] = 8'h3C;
    model_mem[3] = 8'h3C;
    for (int i = 0; i < int'(DEPTH); i++) begin
      checks++;
      if (ram_mem[i] !== model_mem[i]) begin
        errors++;
        $display("FAIL mid_reset_mem addr %0d: got %h want %h", i, ram_mem[i], model_mem[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      logic [AW-1:0] a;
      logic [LW-1:0] len;
      a   = AW'($urandom_range(0, DEPTH - 1));
      len = LW'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_write(a, len, DW'($urandom()));
      else                           do_read(a, len, NONE, 0, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_max_burst();
    do_read(4'd0, 4'd15, 15, 3, 1'b0);
    do_write(4'd0, 4'd15, 8'hC3);
    do_read(4'd0, 4'd15, NONE, 0, 1'b1);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_len   = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = DW'(i * 37 + 11);
    @(negedge clk);
    test_reset();
    test_single_beat();
    test_wrap();
    test_backpressure();
    test_busy_hold();
    test_reset_midburst();
    test_random();
    test_max_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
